// File: rtl/mdu_iterative_if.sv
// EX-stage <-> multiply/divide unit bus: operation launch, MTHI/MTLO writes, status and HI/LO.
// The master is the issuing pipeline; the slave is the MDU that owns HI/LO.
interface mdu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative radix-2 multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide on operand magnitudes for WIDTH cycles, then a sign-fix cycle that writes HI/LO.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mdu_iterative_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [1:0] OP_MULT = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    count_reg;
  logic [1:0]       op_reg;
  logic             neg_a_reg;
  logic             neg_b_reg;
  logic [WIDTH-1:0] a_raw_reg;
  logic [WIDTH-1:0] m_reg;      // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH:0]   upper_reg;  // product high half / partial remainder
  logic [WIDTH-1:0] lower_reg;  // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             done_reg;

  logic             signed_in;
  logic             neg_a_in;
  logic             neg_b_in;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    signed_in = ~bus.op[0];
    neg_a_in  = signed_in & bus.a[WIDTH-1];
    neg_b_in  = signed_in & bus.b[WIDTH-1];
    mag_a     = neg_a_in ? -bus.a : bus.a;
    mag_b     = neg_b_in ? -bus.b : bus.b;
  end

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, upper_reg[WIDTH-1:0]} + (lower_reg[0] ? {1'b0, m_reg} : '0);
    div_shift = {upper_reg[WIDTH-1:0], lower_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_reg};
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Most-negative / -1 needs no special case: the magnitude quotient negates onto itself.
  always_comb begin
    prod = {upper_reg[WIDTH-1:0], lower_reg};
    if (op_reg == OP_MULT && (neg_a_reg ^ neg_b_reg)) begin
      prod = -prod;
    end
    quo = lower_reg;
    rem = upper_reg[WIDTH-1:0];
    if (op_reg == OP_DIV) begin
      if (neg_a_reg ^ neg_b_reg) quo = -quo;
      if (neg_a_reg)             rem = -rem;
    end
    if (op_reg[1]) begin
      if (m_reg == '0) begin
        fix_hi = a_raw_reg;
        fix_lo = '1;
      end else begin
        fix_hi = rem;
        fix_lo = quo;
      end
    end else begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      op_reg    <= '0;
      neg_a_reg <= 1'b0;
      neg_b_reg <= 1'b0;
      a_raw_reg <= '0;
      m_reg     <= '0;
      upper_reg <= '0;
      lower_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.wr_hi) hi_reg <= bus.wr_data;
          if (bus.wr_lo) lo_reg <= bus.wr_data;
          if (bus.start && !bus.flush) begin
            state_reg <= S_RUN;
            count_reg <= '0;
            op_reg    <= bus.op;
            neg_a_reg <= neg_a_in;
            neg_b_reg <= neg_b_in;
            a_raw_reg <= bus.a;
            upper_reg <= '0;
            m_reg     <= bus.op[1] ? mag_b : mag_a;
            lower_reg <= bus.op[1] ? mag_a : mag_b;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            state_reg <= S_IDLE;
          end else begin
            if (op_reg[1]) begin
              // Restoring step: keep the difference only when it did not go negative.
              if (!div_diff[WIDTH]) begin
                upper_reg <= div_diff;
                lower_reg <= {lower_reg[WIDTH-2:0], 1'b1};
              end else begin
                upper_reg <= div_shift;
                lower_reg <= {lower_reg[WIDTH-2:0], 1'b0};
              end
            end else begin
              upper_reg <= {1'b0, mul_sum[WIDTH:1]};
              lower_reg <= {mul_sum[0], lower_reg[WIDTH-1:1]};
            end
            count_reg <= count_reg + CW'(1);
            if (count_reg == LAST) state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          state_reg <= S_IDLE;
          if (!bus.flush) begin
            hi_reg   <= fix_hi;
            lo_reg   <= fix_lo;
            done_reg <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state_reg != S_IDLE);
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed corner cases plus randomized ops on WIDTH=32 and WIDTH=8
// instances, checked against a plain-arithmetic HI/LO model.
module tb_mdu_iterative;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_iterative_if #(.WIDTH(32)) b32 ();
  mdu_iterative_if #(.WIDTH(8))  b8 ();

  mdu_iterative #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  mdu_iterative #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // HI/LO as defined by the instruction set, using 64-bit integer arithmetic.
  function automatic void model(input int w, input logic [1:0] o, input logic [31:0] xi,
                                input logic [31:0] yi, output logic [63:0] h, output logic [63:0] l);
    longint unsigned mask, x, y, up;
    longint sx, sy, p, q, r;
    mask = (64'd1 << w) - 64'd1;
    x = {32'd0, xi} & mask;
    y = {32'd0, yi} & mask;
    sx = (((x >> (w - 1)) & 64'd1) != 0) ? longint'(x) - (longint'(1) << w) : longint'(x);
    sy = (((y >> (w - 1)) & 64'd1) != 0) ? longint'(y) - (longint'(1) << w) : longint'(y);
    h = '0;
    l = '0;
    case (o)
      2'd0: begin p = sx * sy; up = p; h = (up >> w) & mask; l = up & mask; end
      2'd1: begin up = x * y; h = (up >> w) & mask; l = up & mask; end
      2'd2: begin
        if (y == 0) begin h = x; l = mask; end
        else begin
          q = sx / sy; r = sx % sy;
          up = q; l = up & mask;
          up = r; h = up & mask;
        end
      end
      default: begin
        if (y == 0) begin h = x; l = mask; end
        else begin l = x / y; h = x % y; end
      end
    endcase
  endfunction

  task automatic idle_inputs();
    b32.start = 0; b32.op = 0; b32.a = 0; b32.b = 0; b32.flush = 0;
    b32.wr_hi = 0; b32.wr_lo = 0; b32.wr_data = 0;
    b8.start = 0; b8.op = 0; b8.a = 0; b8.b = 0; b8.flush = 0;
    b8.wr_hi = 0; b8.wr_lo = 0; b8.wr_data = 0;
  endtask

  // Called #1 after the launch edge; counts edges (launch edge = 1) until done is seen.
  task automatic wait_done(input bit w8, output int cyc, output int busy_cyc, output bit got);
    cyc = 1; busy_cyc = 0; got = 0;
    while (cyc < 200) begin
      if (w8 ? b8.done : b32.done) begin got = 1; break; end
      if (w8 ? b8.busy : b32.busy) busy_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", {63'd0, got}, 64'd1);
  endtask

  task automatic run_op(input bit w8, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int exp_cyc);
    logic [63:0] eh, el, gh, gl;
    int cyc, busy_cyc;
    bit got;
    model(w8 ? 8 : 32, o, x, y, eh, el);
    @(negedge clk);
    if (w8) begin b8.start = 1; b8.op = o; b8.a = x[7:0]; b8.b = y[7:0]; end
    else    begin b32.start = 1; b32.op = o; b32.a = x; b32.b = y; end
    @(posedge clk); #1;
    b32.start = 0; b8.start = 0;
    wait_done(w8, cyc, busy_cyc, got);
    gh = w8 ? {56'd0, b8.hi} : {32'd0, b32.hi};
    gl = w8 ? {56'd0, b8.lo} : {32'd0, b32.lo};
    check("hi", gh, eh);
    check("lo", gl, el);
    if (exp_cyc > 0) begin
      check("done_latency", 64'(cyc), 64'(exp_cyc));
      check("busy_cycles", 64'(busy_cyc), 64'(exp_cyc - 1));
    end
    $display("[TB] w=%0d op=%0d a=0x%0h b=0x%0h -> hi=0x%0h lo=0x%0h (exp 0x%0h/0x%0h) cyc=%0d",
             w8 ? 8 : 32, o, x, y, gh, gl, eh, el, cyc);
    @(posedge clk); #1;
    check("done_one_cycle", {63'd0, (w8 ? b8.done : b32.done)}, 64'd0);
  endtask

  initial begin
    int cyc, busy_cyc, done_cnt;
    bit got;
    logic [1:0] o;
    logic [31:0] x, y;

    idle_inputs();
    #12;
    check("rst_busy", {63'd0, b32.busy}, 0);
    check("rst_done", {63'd0, b32.done}, 0);
    check("rst_hi", {32'd0, b32.hi}, 0);
    check("rst_lo", {32'd0, b32.lo}, 0);
    @(negedge clk); rst_n = 1;

    // MTHI / MTLO preload
    @(negedge clk); b32.wr_hi = 1; b32.wr_data = 32'h11;
    @(negedge clk); b32.wr_hi = 0; b32.wr_lo = 1; b32.wr_data = 32'h22;
    @(negedge clk); b32.wr_lo = 0;
    check("mthi", {32'd0, b32.hi}, 64'h11);
    check("mtlo", {32'd0, b32.lo}, 64'h22);
    $display("[TB] preload hi=0x%0h lo=0x%0h", b32.hi, b32.lo);

    // DIVU 100/7 with an ignored restart, ignored busy write, then flush
    b32.start = 1; b32.op = 2'd3; b32.a = 100; b32.b = 7;
    done_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (b32.done) done_cnt++;
      check("flush_busy_run", {63'd0, b32.busy}, 1);
      @(negedge clk);
      b32.start = (c == 5); b32.op = 2'd1; b32.a = 9; b32.b = 9;
      b32.wr_hi = (c == 7); b32.wr_data = 32'hDEAD;
      b32.flush = (c == 10);
    end
    @(posedge clk); #1;
    check("flush_busy_drop", {63'd0, b32.busy}, 0);
    @(negedge clk); idle_inputs();
    repeat (40) begin
      @(posedge clk); #1;
      if (b32.done) done_cnt++;
    end
    check("flush_no_done", 64'(done_cnt), 0);
    check("flush_hi_kept", {32'd0, b32.hi}, 64'h11);
    check("flush_lo_kept", {32'd0, b32.lo}, 64'h22);
    $display("[TB] flush test hi=0x%0h lo=0x%0h done_cnt=%0d", b32.hi, b32.lo, done_cnt);

    // flush coincident with start in IDLE drops the start
    @(negedge clk); b32.start = 1; b32.flush = 1; b32.op = 2'd1; b32.a = 3; b32.b = 3;
    @(posedge clk); #1;
    check("flush_start_drop", {63'd0, b32.busy}, 0);
    $display("[TB] start+flush busy=%0d", b32.busy);
    @(negedge clk); idle_inputs();

    // MTLO coincident with start lands at E0, then the result overwrites it
    @(negedge clk); b32.start = 1; b32.op = 2'd3; b32.a = 100; b32.b = 7;
    b32.wr_lo = 1; b32.wr_data = 32'h55;
    @(posedge clk); #1;
    idle_inputs();
    check("wr_with_start", {32'd0, b32.lo}, 64'h55);
    wait_done(0, cyc, busy_cyc, got);
    check("divu_100_7_lo", {32'd0, b32.lo}, 64'd14);
    check("divu_100_7_hi", {32'd0, b32.hi}, 64'd2);
    $display("[TB] wr+start DIVU 100/7 hi=0x%0h lo=0x%0h", b32.hi, b32.lo);

    // asynchronous reset mid-operation
    @(negedge clk); b32.start = 1; b32.op = 2'd1; b32.a = 3; b32.b = 5;
    @(posedge clk); #1; idle_inputs();
    repeat (11) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("arst_busy", {63'd0, b32.busy}, 0);
    check("arst_done", {63'd0, b32.done}, 0);
    check("arst_hi", {32'd0, b32.hi}, 0);
    check("arst_lo", {32'd0, b32.lo}, 0);
    $display("[TB] async reset busy=%0d hi=0x%0h lo=0x%0h", b32.busy, b32.hi, b32.lo);
    @(negedge clk); rst_n = 1;
    repeat (2) @(posedge clk); #1;
    check("arst_idle", {63'd0, b32.busy}, 0);
    run_op(0, 2'd1, 3, 5, 34);

    // directed corner cases
    run_op(0, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op(0, 2'd0, 32'hFFFFFFF9, 32'd3, 34);
    run_op(0, 2'd0, 32'h80000000, 32'h80000000, 34);
    run_op(0, 2'd2, 32'hFFFFFFF9, 32'd2, 34);
    run_op(0, 2'd3, 32'd7, 32'd0, 34);
    run_op(0, 2'd2, 32'h80000000, 32'hFFFFFFFF, 34);
    run_op(0, 2'd2, 32'hFFFFFFF9, 32'd0, 34);
    run_op(1, 2'd0, 32'h80, 32'h80, 10);
    run_op(1, 2'd3, 32'hFF, 32'h10, 10);
    run_op(1, 2'd2, 32'h80, 32'hFF, 10);

    // randomized
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFFFFFF;
        2: y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      run_op(0, o, x, y, 34);
    end
    for (int i = 0; i < 20; i++) begin
      o = 2'($urandom_range(0, 3));
      run_op(1, o, $urandom, ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom, 10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
